// File: rtl/io_register_block.sv
// ---------------------------------------------------------------------------
// io_register_block
//   Memory-mapped input peripheral for the game SoC. Each button pin is
//   synchronised and debounced; debounced rising edges are latched as press
//   events and sprite collision flags are latched as sticky bits. Both stay
//   latched until software reads them. Entries into vblank are counted in a
//   16-bit frame counter.
//
// Ports
//   clk                   system clock
//   reset                 synchronous, active-high reset
//   buttons               raw asynchronous button pins
//   in_vblank             vertical-blank level (already synchronous to clk)
//   collision             live sprite-collision flags
//   register_index        CPU register address
//   register_read         one-cycle read strobe
//   register_write        one-cycle write strobe
//   register_write_value  write data
//   register_read_value   registered read data, held between reads
//
// Register map (unmapped indices and unused upper bits read as 0)
//   0 R   debounced button levels
//   1 R   in_vblank in bit 0
//   2 R   sticky collision flags, cleared by the read
//   3 R   press events, cleared by the read
//   4 RW  frame counter, a write loads it
//   5 R   live collision flags
// ---------------------------------------------------------------------------
module io_register_block #(
    parameter int NUM_BUTTONS     = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_COLLISION   = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_BUTTONS-1:0]   buttons,
    input  logic                     in_vblank,
    input  logic [NUM_COLLISION-1:0] collision,
    input  logic [11:0]              register_index,
    input  logic                     register_read,
    input  logic                     register_write,
    input  logic [15:0]              register_write_value,
    output logic [15:0]              register_read_value
);

    // Counter only ever needs to hold 0..DEBOUNCE_CYCLES-1.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [11:0] IDX_LEVELS    = 12'd0;
    localparam logic [11:0] IDX_VBLANK    = 12'd1;
    localparam logic [11:0] IDX_COLL_STKY = 12'd2;
    localparam logic [11:0] IDX_PRESS     = 12'd3;
    localparam logic [11:0] IDX_FRAME     = 12'd4;
    localparam logic [11:0] IDX_COLL_LIVE = 12'd5;

    logic [NUM_BUTTONS-1:0] level_q;
    logic [NUM_BUTTONS-1:0] level_d;

    // -----------------------------------------------------------------------
    // Per-button synchroniser and debouncer
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_button
            logic [SYNC_STAGES-1:0] sync_q;
            logic [CNT_W-1:0]       cnt_q;
            logic [CNT_W-1:0]       cnt_d;
            logic                   lvl_q;
            logic                   lvl_d;
            logic                   synced;

            assign synced = sync_q[SYNC_STAGES-1];

            // The level only moves after DEBOUNCE_CYCLES consecutive cycles
            // of disagreement; any agreeing cycle restarts the count.
            always_comb begin
                cnt_d = '0;
                lvl_d = lvl_q;
                if (synced != lvl_q) begin
                    if (cnt_q == CNT_LAST) begin
                        lvl_d = synced;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= '0;
                    cnt_q  <= '0;
                    lvl_q  <= 1'b0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], buttons[gi]};
                    cnt_q  <= cnt_d;
                    lvl_q  <= lvl_d;
                end
            end

            assign level_q[gi] = lvl_q;
            assign level_d[gi] = lvl_d;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Event latches, frame counter and read port
    // -----------------------------------------------------------------------
    logic [NUM_BUTTONS-1:0]   press_q;
    logic [NUM_BUTTONS-1:0]   press_d;
    logic [NUM_COLLISION-1:0] coll_q;
    logic [NUM_COLLISION-1:0] coll_d;
    logic [15:0]              frame_q;
    logic [15:0]              frame_d;
    logic                     vblank_prev_q;
    logic [15:0]              rdata_q;
    logic [15:0]              rdata_d;

    logic read_coll;
    logic read_press;
    logic write_frame;

    assign read_coll   = register_read  && (register_index == IDX_COLL_STKY);
    assign read_press  = register_read  && (register_index == IDX_PRESS);
    assign write_frame = register_write && (register_index == IDX_FRAME);

    always_comb begin
        // Clear happens first so an event arriving in the read cycle survives.
        press_d = (read_press ? '0 : press_q) | (level_d & ~level_q);
        coll_d  = (read_coll  ? '0 : coll_q)  | collision;

        // A CPU write takes priority over a coincident vblank entry.
        frame_d = frame_q;
        if (write_frame) begin
            frame_d = register_write_value;
        end else if (in_vblank && !vblank_prev_q) begin
            frame_d = frame_q + 16'd1;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (register_read) begin
            rdata_d = '0;
            case (register_index)
                IDX_LEVELS:    rdata_d[NUM_BUTTONS-1:0]   = level_q;
                IDX_VBLANK:    rdata_d[0]                 = in_vblank;
                IDX_COLL_STKY: rdata_d[NUM_COLLISION-1:0] = coll_q;
                IDX_PRESS:     rdata_d[NUM_BUTTONS-1:0]   = press_q;
                IDX_FRAME:     rdata_d                    = frame_q;
                IDX_COLL_LIVE: rdata_d[NUM_COLLISION-1:0] = collision;
                default:       rdata_d                    = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            press_q       <= '0;
            coll_q        <= '0;
            frame_q       <= '0;
            vblank_prev_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            press_q       <= press_d;
            coll_q        <= coll_d;
            frame_q       <= frame_d;
            vblank_prev_q <= in_vblank;
            rdata_q       <= rdata_d;
        end
    end

    assign register_read_value = rdata_q;

endmodule
